register_file_structural: RTL and testbench

//  - Three-port register file for the datapath: two combinational read ports (A1/RD1, A2/RD2) and one synchronous write port (A3/WD3/WE3).
//  - Holds 2**N entries of M bits. Physical storage is R0..R(2**N-2).
//  - The top address (R15 for N=4) is not stored; reads of it return the R15 input, which carries the PC-derived value from the fetch stage.
//  - Built structurally:
//    - write-address decoder -> per-register write enables;
//    - enabled D-flip-flop registers with synchronous reset;
//    - one 2**N:1 read mux per read port.

---
 rtl/register_file_structural_if.sv | 41 ++++
 rtl/register_file_structural.sv | 83 ++++++++
 tb/tb_register_file_structural.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/register_file_structural_if.sv
// -----------------------------------------------------------------------------
// register_file_structural_if
//   Bus bundle for the three-port register file: two read ports and one write
//   port, plus the externally supplied value returned for the top address.
//
//   Signals (N = address width, M = data width)
//     WE3      1   write enable, port 3
//     A1, A2   N   read addresses, ports 1 and 2
//     A3       N   write address, port 3
//     WD3      M   write data, port 3
//     R15      M   value returned for reads of address 2**N-1 (PC-derived)
//     RD1,RD2  M   combinational read data, ports 1 and 2
//
//   master : the datapath side (drives addresses/data, receives read data)
//   slave  : the register file itself
// -----------------------------------------------------------------------------
interface register_file_structural_if #(
   parameter int N = 4,
   parameter int M = 32
) ();

   logic         WE3;
   logic [N-1:0] A1;
   logic [N-1:0] A2;
   logic [N-1:0] A3;
   logic [M-1:0] WD3;
   logic [M-1:0] R15;
   logic [M-1:0] RD1;
   logic [M-1:0] RD2;

   modport master (
      output WE3, A1, A2, A3, WD3, R15,
      input  RD1, RD2
   );

   modport slave (
      input  WE3, A1, A2, A3, WD3, R15,
      output RD1, RD2
   );

endinterface

// File: rtl/register_file_structural.sv
// -----------------------------------------------------------------------------
// register_file_structural
//   Three-port register file for the datapath, built structurally from a
//   write-address decoder, a bank of enabled D flip-flop registers with
//   synchronous reset, and one 2**N:1 read multiplexer per read port.
//
//   Only entries 0 .. 2**N-2 are stored. The top address is not backed by
//   storage: reads of it return the R15 bus input (PC-derived value from the
//   fetch stage) and writes to it are dropped.
//
//   Ports
//     clk    in   1   rising-edge clock for all state
//     reset  in   1   synchronous, active-high; clears every stored register
//     rf     slave    register_file_structural_if bundle:
//                     WE3/A3/WD3 write port, A1/RD1 and A2/RD2 read ports,
//                     R15 value for the top address
//
//   Timing
//     Writes take effect at the rising edge; reads are purely combinational,
//     so a read of the register being written shows the old contents until
//     that edge (no write-through bypass).
// -----------------------------------------------------------------------------
module register_file_structural #(
   parameter int N = 4,
   parameter int M = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   register_file_structural_if.slave   rf
);

   localparam int NENT = 2 ** N;    // addressable entries
   localparam int NREG = NENT - 1;  // physically stored entries

   // Balanced 2:1 mux tree, one level per address bit (LSB first). Each level
   // folds pairs (2j, 2j+1) into slot j in place; slots >= 2j are still
   // untouched when slot j is written, so no temporary array is needed.
   // An X on a select bit yields X on the differing data bits.
   function automatic logic [M-1:0] read_mux(
      input logic [NENT-1:0][M-1:0] src,
      input logic [N-1:0]           sel
   );
      logic [NENT-1:0][M-1:0] cur;
      cur = src;
      for (int l = 0; l < N; l++) begin
         for (int j = 0; j < (NENT >> (l + 1)); j++) begin
            cur[j] = sel[l] ? cur[2 * j + 1] : cur[2 * j];
         end
      end
      return cur[0];
   endfunction

   logic [NREG-1:0]         en;      // one-hot per-register write enables
   logic [NENT-1:0][M-1:0]  rd_src;  // read-mux inputs: registers + R15

   // ---- write-address decoder ----------------------------------------------
   // A3 = 2**N-1 matches no stored register, so such writes fall away here.
   for (genvar i = 0; i < NREG; i++) begin : g_dec
      assign en[i] = rf.WE3 & (rf.A3 == N'(i));
   end

   // ---- register bank -------------------------------------------------------
   for (genvar i = 0; i < NREG; i++) begin : g_reg
      logic [M-1:0] q;

      always_ff @(posedge clk) begin
         if (reset) begin
            q <= '0;
         end else if (en[i]) begin
            q <= rf.WD3;
         end
      end

      assign rd_src[i] = q;
   end

   assign rd_src[NENT-1] = rf.R15;

   // ---- read ports ----------------------------------------------------------
   assign rf.RD1 = read_mux(rd_src, rf.A1);
   assign rf.RD2 = read_mux(rd_src, rf.A2);

endmodule

// File: tb/tb_register_file_structural.sv
// -----------------------------------------------------------------------------
// tb_register_file_structural
//   Directed-vector bench for register_file_structural (N=4, M=32). Inputs are
//   driven 1 time unit after each rising edge; read data is sampled a further
//   1 time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_register_file_structural;

   localparam int N = 4;
   localparam int M = 32;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   register_file_structural_if #(.N(N), .M(M)) bus ();

   register_file_structural #(.N(N), .M(M)) dut (
      .clk   (clk),
      .reset (reset),
      .rf    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [M-1:0] got,
                           input logic [M-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      bus.WE3   = 1'b0;
      bus.A1    = '0;
      bus.A2    = '0;
      bus.A3    = '0;
      bus.WD3   = '0;
      bus.R15   = '0;

      // ---- 1: reset clears all stored registers ----
      tick();
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         bus.A1 = N'(i);
         bus.A2 = N'(i);
         #1;
         check_eq($sformatf("rst_rd1[%0d]", i), bus.RD1, 32'h0);
         check_eq($sformatf("rst_rd2[%0d]", i), bus.RD2, 32'h0);
      end
      bus.A1 = 4'd15;
      #1;
      check_eq("rst_r15", bus.RD1, 32'h0);

      // ---- 2: write i to register i, read back on both ports ----
      bus.WE3 = 1'b1;
      for (int i = 0; i < 15; i++) begin
         bus.A3  = N'(i);
         bus.WD3 = M'(i);
         tick();
      end
      bus.WE3 = 1'b0;
      for (int i = 0; i < 15; i++) begin
         bus.A1 = N'(i);
         bus.A2 = N'(14 - i);
         #1;
         check_eq($sformatf("wr_rd1[%0d]", i), bus.RD1, M'(i));
         check_eq($sformatf("wr_rd2[%0d]", 14 - i), bus.RD2, M'(14 - i));
      end

      // ---- 3: WE3 gating ----
      bus.WE3 = 1'b0;
      bus.A3  = 4'd0;
      bus.WD3 = 32'h0F0F0F0F;
      bus.A1  = 4'd0;
      bus.A2  = 4'd1;
      for (int k = 0; k < 10; k++) tick();
      check_eq("gate_hold_r0", bus.RD1, 32'h0);
      check_eq("gate_hold_r1", bus.RD2, 32'h1);
      bus.WE3 = 1'b1;
      tick();
      bus.WE3 = 1'b0;
      #1;
      check_eq("gate_write_r0", bus.RD1, 32'h0F0F0F0F);
      check_eq("gate_other_r1", bus.RD2, 32'h1);

      // ---- 4: R15 path ----
      bus.R15 = 32'h00000108;
      bus.A1  = 4'd15;
      bus.A2  = 4'd15;
      #1;
      check_eq("r15_rd1", bus.RD1, 32'h00000108);
      check_eq("r15_rd2", bus.RD2, 32'h00000108);
      bus.R15 = 32'h00001234;
      #1;
      check_eq("r15_chg_rd1", bus.RD1, 32'h00001234);
      check_eq("r15_chg_rd2", bus.RD2, 32'h00001234);
      bus.WE3 = 1'b1;
      bus.A3  = 4'd15;
      bus.WD3 = 32'h0000DEAD;
      tick();
      bus.WE3 = 1'b0;
      #1;
      check_eq("r15_nowrite", bus.RD1, 32'h00001234);
      for (int i = 0; i < 15; i++) begin
         bus.A2 = N'(i);
         #1;
         check_eq($sformatf("r15_keep[%0d]", i), bus.RD2,
                  (i == 0) ? 32'h0F0F0F0F : M'(i));
      end

      // ---- 6: read during write ----
      bus.WE3 = 1'b1;
      bus.A3  = 4'd2;
      bus.WD3 = 32'hA;
      tick();
      bus.WD3 = 32'hB;
      bus.A1  = 4'd2;
      bus.A2  = 4'd5;
      #1;
      check_eq("rdw_before", bus.RD1, 32'hA);
      check_eq("rdw_rd2_before", bus.RD2, 32'h5);
      tick();
      bus.WE3 = 1'b0;
      #1;
      check_eq("rdw_after", bus.RD1, 32'hB);
      check_eq("rdw_rd2_after", bus.RD2, 32'h5);

      // ---- 5: reset priority over a concurrent write ----
      reset   = 1'b1;
      bus.WE3 = 1'b1;
      bus.A3  = 4'd3;
      bus.WD3 = 32'h5;
      tick();
      tick();
      reset   = 1'b0;
      bus.WE3 = 1'b0;
      bus.A1  = 4'd3;
      #1;
      check_eq("rstpri_r3", bus.RD1, 32'h0);
      for (int i = 0; i < 15; i++) begin
         bus.A1 = N'(i);
         bus.A2 = N'(14 - i);
         #1;
         check_eq($sformatf("rstpri_rd1[%0d]", i), bus.RD1, 32'h0);
         check_eq($sformatf("rstpri_rd2[%0d]", 14 - i), bus.RD2, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
